// File: rtl/signed_accum.sv
// Block accumulator: sums LEN signed samples into an ACC_W-bit result with a sticky overflow flag.
// Optional saturation on step overflow is enabled by defining SIGNED_ACCUM_SAT_EN (default: wrap).
module signed_accum #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 10,
    parameter int LEN   = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

`ifdef SIGNED_ACCUM_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] in_ext;
    logic signed [ACC_W:0] sum;
    logic                  step_ovf;
    logic [ACC_W-1:0]      step_res;

    // One guard bit makes the sum exact; disagreeing top bits mean the ACC_W result overflowed.
    always_comb begin
        acc_ext  = (ACC_W+1)'(signed'(acc_q));
        in_ext   = (ACC_W+1)'(signed'(in_data));
        sum      = acc_ext + in_ext;
        step_ovf = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef SIGNED_ACCUM_SAT_EN
        if (step_ovf) begin
            step_res = sum[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            step_res = sum[ACC_W-1:0];
        end
`else
        step_res = sum[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        in_ready   = (state_q == ACCUM);
        out_valid  = (state_q == HOLD);

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (count_q == LAST_C) begin
                        out_data_d = step_res;
                        out_ovf_d  = ovf_q | step_ovf;
                        acc_d      = '0;
                        count_d    = '0;
                        ovf_d      = 1'b0;
                        state_d    = HOLD;
                    end else begin
                        acc_d   = step_res;
                        count_d = count_q + CNT_W'(1);
                        ovf_d   = ovf_q | step_ovf;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign out_data = out_data_q;
    assign out_ovf  = out_ovf_q;
    assign count    = count_q;

endmodule

// File: tb/tb_signed_accum.sv
// Scoreboard bench for signed_accum: directed blocks push expected results, a monitor checks handshakes.
module tb_signed_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] out_data;
    logic       out_ovf;
    logic [3:0] count;

    int tests  = 0;
    int errors = 0;
    logic [10:0] sb[$];

    signed_accum #(.IN_W(8), .ACC_W(10), .LEN(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input bit o);
        sb.push_back({o, 10'(d)});
    endtask

    // Present one sample and hold it until it is accepted on a rising edge.
    task automatic send(input int v);
        int budget;
        budget = 0;
        in_valid = 1'b1;
        in_data  = 8'(v);
        @(negedge clk);
        while (!in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            tests++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for sample %0d", v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int v);
        for (int i = 0; i < 8; i++) send(v);
    endtask

    // Monitor: a handshake completes on the rising edge after a negedge with valid && ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: result data=%0d ovf=%0d with empty scoreboard",
                         $signed(out_data), out_ovf);
            end else begin
                logic [10:0] e;
                e = sb.pop_front();
                if (out_data !== e[9:0] || out_ovf !== e[10]) begin
                    errors++;
                    $display("FAIL sb_result: got data=%0d ovf=%0d, expected data=%0d ovf=%0d",
                             $signed(out_data), out_ovf, $signed(e[9:0]), e[10]);
                end else begin
                    $display("[TB] result data=%0d ovf=%0d ok", $signed(out_data), out_ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        #12;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_count", int'(count), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_ovf", int'(out_ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic sum: 8 x -2
        push_exp(-16, 1'b0);
        send_block(-2);
        check("basic_latency_out_valid", int'(out_valid), 1);
        check("basic_count_cleared", int'(count), 0);
        check("basic_in_ready_hold", int'(in_ready), 0);

        // Positive overflow: 8 x +127
`ifdef SIGNED_ACCUM_SAT_EN
        push_exp(511, 1'b1);
`else
        push_exp(-8, 1'b1);
`endif
        send_block(127);

        // Negative edge: 8 x -128
`ifdef SIGNED_ACCUM_SAT_EN
        push_exp(-512, 1'b1);
`else
        push_exp(0, 1'b1);
`endif
        send_block(-128);

        // Backpressure with gaps: samples 1..8, in_valid toggled
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push_exp(36, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            send(i);
            if (i == 4) check("gap_count_mid", int'(count), 4);
            if (i < 8) begin
                @(posedge clk);
                #1;
            end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", int'($signed(out_data)), 36);
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);

        // Reset mid-block
        for (int i = 0; i < 3; i++) send(10);
        check("partial_count", int'(count), 3);
        rst = 1'b1;
        #1;
        check("midrst_count", int'(count), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_exp(8, 1'b0);
        send_block(1);

        // Sticky flag clears between blocks
`ifdef SIGNED_ACCUM_SAT_EN
        push_exp(511, 1'b1);
`else
        push_exp(-8, 1'b1);
`endif
        send_block(127);
        push_exp(8, 1'b0);
        send_block(1);

        budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
